fifo_burst_wr: RTL and testbench

//  Parametrised FIFO write controller: refill a FIFO in bursts from a valid/ready source.

---
 rtl/fifo_burst_wr_pkg.sv | 17 +
 rtl/sync_bit.sv | 23 ++
 rtl/fifo_burst_wr.sv | 143 ++++++++++++++
 tb/tb_fifo_burst_wr.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_burst_wr_pkg.sv
// rtl/fifo_burst_wr_pkg.sv - shared types and constants for the burst FIFO write controller
package fifo_burst_wr_pkg;

    localparam int CNT_W         = 16;
    localparam int DEF_DATA_W    = 8;
    localparam int DEF_BURST_LEN = 16;
    localparam int DEF_WAIT_CYC  = 10;
    localparam int DEF_SYNC_STG  = 2;

    typedef enum logic [3:0] {
        IDLE   = 4'b0001,
        SETTLE = 4'b0010,
        BURST  = 4'b0100,
        DONE   = 4'b1000
    } state_e;

endpackage

// File: rtl/sync_bit.sv
// rtl/sync_bit.sv - multi-flop single-bit synchroniser with synchronous active-high reset
module sync_bit #(
    parameter int STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/fifo_burst_wr.sv
// rtl/fifo_burst_wr.sv - burst FIFO refill controller; optional stats counter under FIFO_BURST_WR_STATS_EN
module fifo_burst_wr
    import fifo_burst_wr_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int BURST_LEN = DEF_BURST_LEN,
    parameter int WAIT_CYC  = DEF_WAIT_CYC,
    parameter int SYNC_STG  = DEF_SYNC_STG
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              almost_empty,
    input  logic              almost_full,
    input  logic              s_valid,
    input  logic [DATA_W-1:0] s_data,
    output logic              s_ready,
    output logic              fifo_wr_en,
    output logic [DATA_W-1:0] fifo_wr_data,
    output logic              busy,
    output logic              wr_done,
    output logic              wr_short,
    output logic [CNT_W-1:0]  wr_cnt,
    output logic [31:0]       stat_words
);

    localparam logic [7:0] SETTLE_LAST = (WAIT_CYC == 0) ? 8'd0 : 8'(WAIT_CYC - 1);
    // Unlimited bursts still end when the counter would otherwise wrap.
    localparam logic [CNT_W-1:0] BURST_LAST = (BURST_LEN == 0) ?
        {{(CNT_W-1){1'b1}}, 1'b0} : CNT_W'(BURST_LEN - 1);

    logic              ae_s;
    state_e            state_q;
    logic [7:0]        dly_q;
    logic [CNT_W-1:0]  beat_q;
    logic [CNT_W-1:0]  wr_cnt_q;
    logic              wr_en_q;
    logic [DATA_W-1:0] wr_data_q;
    logic              busy_q;
    logic              done_q;
    logic              short_q;
    logic              accept;
    logic              last_beat;

    sync_bit #(
        .STAGES(SYNC_STG)
    ) u_ae_sync (
        .clk_i(sys_clk),
        .rst_i(sys_rst),
        .d_i  (almost_empty),
        .q_o  (ae_s)
    );

    assign s_ready   = (state_q == BURST) && !almost_full;
    assign accept    = s_valid && s_ready;
    assign last_beat = accept && (beat_q == BURST_LAST);

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q   <= IDLE;
            dly_q     <= '0;
            beat_q    <= '0;
            wr_cnt_q  <= '0;
            wr_en_q   <= 1'b0;
            wr_data_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            short_q   <= 1'b0;
        end else begin
            wr_en_q <= accept;
            if (accept) begin
                wr_data_q <= s_data;
            end
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (ae_s) begin
                        state_q <= SETTLE;
                        busy_q  <= 1'b1;
                        dly_q   <= '0;
                    end
                end
                SETTLE: begin
                    if (dly_q == SETTLE_LAST) begin
                        state_q <= BURST;
                    end else begin
                        dly_q <= dly_q + 8'd1;
                    end
                end
                BURST: begin
                    // Reaching the length limit wins over almost_full.
                    if (last_beat) begin
                        state_q  <= DONE;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        short_q  <= 1'b0;
                        wr_cnt_q <= beat_q + 1'b1;
                        beat_q   <= '0;
                    end else if (almost_full) begin
                        state_q  <= DONE;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        short_q  <= 1'b1;
                        wr_cnt_q <= beat_q;
                        beat_q   <= '0;
                    end else if (accept) begin
                        beat_q <= beat_q + 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign fifo_wr_en   = wr_en_q;
    assign fifo_wr_data = wr_data_q;
    assign busy         = busy_q;
    assign wr_done      = done_q;
    assign wr_short     = short_q;
    assign wr_cnt       = wr_cnt_q;

`ifdef FIFO_BURST_WR_STATS_EN
    logic [31:0] stat_q;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            stat_q <= '0;
        end else if (wr_en_q && (stat_q != 32'hFFFF_FFFF)) begin
            stat_q <= stat_q + 32'd1;
        end
    end

    assign stat_words = stat_q;
`else
    assign stat_words = 32'd0;
`endif

endmodule

// File: tb/tb_fifo_burst_wr.sv
// tb/tb_fifo_burst_wr.sv - scoreboard bench for fifo_burst_wr
module tb_fifo_burst_wr;

    logic        sys_clk = 1'b0;
    logic        sys_rst;
    logic        almost_empty;
    logic        almost_full;
    logic        s_valid;
    logic [7:0]  s_data;
    logic        s_ready;
    logic        fifo_wr_en;
    logic [7:0]  fifo_wr_data;
    logic        busy;
    logic        wr_done;
    logic        wr_short;
    logic [15:0] wr_cnt;
    logic [31:0] stat_words;

    int          checks   = 0;
    int          failures = 0;
    logic [7:0]  sb[$];
    int          wr_seen   = 0;
    int          done_seen = 0;
    logic [15:0] last_cnt  = '0;
    logic        last_short = 1'b0;
    logic [7:0]  exp_data;

    fifo_burst_wr #(
        .DATA_W   (8),
        .BURST_LEN(16),
        .WAIT_CYC (10),
        .SYNC_STG (2)
    ) dut (
        .sys_clk     (sys_clk),
        .sys_rst     (sys_rst),
        .almost_empty(almost_empty),
        .almost_full (almost_full),
        .s_valid     (s_valid),
        .s_data      (s_data),
        .s_ready     (s_ready),
        .fifo_wr_en  (fifo_wr_en),
        .fifo_wr_data(fifo_wr_data),
        .busy        (busy),
        .wr_done     (wr_done),
        .wr_short    (wr_short),
        .wr_cnt      (wr_cnt),
        .stat_words  (stat_words)
    );

    always #5 sys_clk = ~sys_clk;

    always @(negedge sys_clk) begin
        if (fifo_wr_en === 1'b1) begin
            wr_seen++;
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL wr_data_unexpected: got write data=%h, no write expected", fifo_wr_data);
            end else begin
                exp_data = sb.pop_front();
                if (fifo_wr_data !== exp_data) begin
                    failures++;
                    $display("FAIL wr_data: got %h expected %h", fifo_wr_data, exp_data);
                end
            end
        end
        if (wr_done === 1'b1) begin
            done_seen++;
            last_cnt   = wr_cnt;
            last_short = wr_short;
        end
    end

    task automatic do_reset();
        @(negedge sys_clk);
        sys_rst      = 1'b1;
        almost_empty = 1'b0;
        almost_full  = 1'b0;
        s_valid      = 1'b0;
        s_data       = 8'h00;
        repeat (2) @(negedge sys_clk);
        sys_rst   = 1'b0;
        sb.delete();
        wr_seen   = 0;
        done_seen = 0;
    endtask

    task automatic test_reset();
        @(negedge sys_clk);
        sys_rst      = 1'b1;
        almost_empty = 1'b1;
        almost_full  = 1'b0;
        s_valid      = 1'b1;
        s_data       = 8'hA5;
        for (int i = 0; i < 5; i++) begin
            @(negedge sys_clk);
            checks++;
            if ({s_ready, fifo_wr_en, fifo_wr_data, busy, wr_done, wr_short, wr_cnt, stat_words} !== '0) begin
                failures++;
                $display("FAIL reset_outputs: got rdy=%b en=%b data=%h busy=%b done=%b short=%b cnt=%0d stat=%0d expected all 0",
                         s_ready, fifo_wr_en, fifo_wr_data, busy, wr_done, wr_short, wr_cnt, stat_words);
            end
        end
        sys_rst = 1'b0;
        s_valid = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            @(negedge sys_clk);
            checks++;
            if (busy !== (i == 3)) begin
                failures++;
                $display("FAIL reset_arming: cycle %0d after release busy=%b expected %b", i, busy, (i == 3));
            end
        end
        do_reset();
    endtask

    task automatic test_full_burst();
        int first;
        int d;
        do_reset();
        first = -1;
        d     = 0;
        almost_empty = 1'b1;
        for (int c = 1; c <= 100 && done_seen == 0; c++) begin
            @(negedge sys_clk);
            if (fifo_wr_en === 1'b1 && first < 0) first = c;
            if (c == 2) begin
                checks++;
                if (s_ready !== 1'b0) begin
                    failures++;
                    $display("FAIL idle_ready: s_ready=%b expected 0", s_ready);
                end
            end
            if (c == 5) almost_empty = 1'b0;
            s_valid = (d < 16);
            s_data  = d[7:0];
            #1;
            if (c == 13) begin
                checks++;
                if (busy !== 1'b1 || s_ready !== 1'b1) begin
                    failures++;
                    $display("FAIL burst_entry: busy=%b s_ready=%b expected 1 1", busy, s_ready);
                end
            end
            if (s_valid && s_ready) begin
                sb.push_back(s_data);
                d++;
            end
        end
        s_valid = 1'b0;
        repeat (3) @(negedge sys_clk);
        checks++;
        if (first != 14) begin
            failures++;
            $display("FAIL first_write_latency: got %0d cycles expected 14", first);
        end
        checks++;
        if (wr_seen != 16 || sb.size() != 0) begin
            failures++;
            $display("FAIL full_burst_writes: got %0d writes, %0d pending expected 16, 0", wr_seen, sb.size());
        end
        checks++;
        if (done_seen != 1 || last_cnt !== 16'd16 || last_short !== 1'b0) begin
            failures++;
            $display("FAIL full_burst_done: done=%0d cnt=%0d short=%b expected 1 16 0", done_seen, last_cnt, last_short);
        end
        checks++;
        if (busy !== 1'b0 || wr_cnt !== 16'd16) begin
            failures++;
            $display("FAIL full_burst_hold: busy=%b wr_cnt=%0d expected 0 16", busy, wr_cnt);
        end
    endtask

    task automatic test_early_stop();
        int nacc;
        do_reset();
        nacc = 0;
        almost_empty = 1'b1;
        for (int c = 1; c <= 100 && done_seen == 0; c++) begin
            @(negedge sys_clk);
            if (c == 5) almost_empty = 1'b0;
            if (nacc == 5) almost_full = 1'b1;
            s_valid = 1'b1;
            s_data  = 8'h40 + nacc[7:0];
            #1;
            if (nacc == 5 && c < 100 && almost_full && busy) begin
                checks++;
                if (s_ready !== 1'b0) begin
                    failures++;
                    $display("FAIL early_stop_ready: s_ready=%b expected 0", s_ready);
                end
            end
            if (s_valid && s_ready) begin
                sb.push_back(s_data);
                nacc++;
            end
        end
        s_valid     = 1'b0;
        almost_full = 1'b0;
        repeat (3) @(negedge sys_clk);
        checks++;
        if (done_seen != 1 || last_cnt !== 16'd5 || last_short !== 1'b1) begin
            failures++;
            $display("FAIL early_stop_done: done=%0d cnt=%0d short=%b expected 1 5 1", done_seen, last_cnt, last_short);
        end
        checks++;
        if (wr_seen != 5 || sb.size() != 0) begin
            failures++;
            $display("FAIL early_stop_writes: got %0d writes, %0d pending expected 5, 0", wr_seen, sb.size());
        end
    endtask

    task automatic test_source_gaps();
        int nacc;
        do_reset();
        nacc = 0;
        almost_empty = 1'b1;
        for (int c = 1; c <= 200 && done_seen == 0; c++) begin
            @(negedge sys_clk);
            if (c == 5) almost_empty = 1'b0;
            s_valid = c[0] && (nacc < 16);
            s_data  = 8'($urandom_range(0, 255));
            #1;
            if (s_valid && s_ready) begin
                sb.push_back(s_data);
                nacc++;
            end
        end
        s_valid = 1'b0;
        repeat (3) @(negedge sys_clk);
        checks++;
        if (done_seen != 1 || last_cnt !== 16'd16 || last_short !== 1'b0) begin
            failures++;
            $display("FAIL gaps_done: done=%0d cnt=%0d short=%b expected 1 16 0", done_seen, last_cnt, last_short);
        end
        checks++;
        if (wr_seen != 16 || sb.size() != 0) begin
            failures++;
            $display("FAIL gaps_writes: got %0d writes, %0d pending expected 16, 0", wr_seen, sb.size());
        end
    endtask

    task automatic test_reset_mid_burst();
        int nacc;
        bit fired;
        do_reset();
        nacc  = 0;
        fired = 0;
        almost_empty = 1'b1;
        for (int c = 1; c <= 100 && !fired; c++) begin
            @(negedge sys_clk);
            if (c == 5) almost_empty = 1'b0;
            if (nacc == 7) begin
                sys_rst = 1'b1;
                s_valid = 1'b0;
                fired   = 1;
            end else begin
                s_valid = 1'b1;
                s_data  = 8'h80 + nacc[7:0];
                #1;
                if (s_valid && s_ready) begin
                    sb.push_back(s_data);
                    nacc++;
                end
            end
        end
        @(negedge sys_clk);
        checks++;
        if (fifo_wr_en !== 1'b0 || busy !== 1'b0 || !fired) begin
            failures++;
            $display("FAIL mid_reset_state: wr_en=%b busy=%b reset_applied=%0d expected 0 0 1", fifo_wr_en, busy, fired);
        end
        sys_rst = 1'b0;
        repeat (30) @(negedge sys_clk);
        checks++;
        if (done_seen != 0) begin
            failures++;
            $display("FAIL mid_reset_done: wr_done pulsed %0d times expected 0", done_seen);
        end
        checks++;
        if (wr_seen != 7 || sb.size() != 0) begin
            failures++;
            $display("FAIL mid_reset_writes: got %0d writes, %0d pending expected 7, 0", wr_seen, sb.size());
        end
    endtask

    task automatic test_back_to_back_stats();
        int d;
        do_reset();
        d = 0;
        almost_empty = 1'b1;
        for (int c = 1; c <= 400 && done_seen < 3; c++) begin
            @(negedge sys_clk);
            if (done_seen >= 2) almost_empty = 1'b0;
            s_valid = 1'b1;
            s_data  = d[7:0];
            #1;
            if (s_valid && s_ready) begin
                sb.push_back(s_data);
                d++;
            end
        end
        s_valid = 1'b0;
        repeat (20) @(negedge sys_clk);
        checks++;
        if (done_seen != 3 || wr_seen != 48 || sb.size() != 0) begin
            failures++;
            $display("FAIL b2b_bursts: done=%0d writes=%0d pending=%0d expected 3 48 0", done_seen, wr_seen, sb.size());
        end
        checks++;
        if (busy !== 1'b0 || last_cnt !== 16'd16) begin
            failures++;
            $display("FAIL b2b_idle: busy=%b last_cnt=%0d expected 0 16", busy, last_cnt);
        end
        checks++;
`ifdef FIFO_BURST_WR_STATS_EN
        if (stat_words !== 32'd48) begin
            failures++;
            $display("FAIL stat_words: got %0d expected 48", stat_words);
        end
`else
        if (stat_words !== 32'd0) begin
            failures++;
            $display("FAIL stat_words: got %0d expected 0", stat_words);
        end
`endif
    endtask

    initial begin
        sys_rst      = 1'b1;
        almost_empty = 1'b0;
        almost_full  = 1'b0;
        s_valid      = 1'b0;
        s_data       = 8'h00;
        test_reset();
        test_full_burst();
        test_early_stop();
        test_source_gaps();
        test_reset_mid_burst();
        test_back_to_back_stats();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
